// File: rtl/mc_array_driver.sv
// Row-level write / read sequencer for the 64x64 memristor crossbar macro.
// Optional write-verify readback is built when MC_DRV_VERIFY_EN is defined.
module mc_array_driver #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int EVAL_CYC  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [5:0]  req_row_i,
   input  logic [63:0] req_mask_i,
   input  logic [63:0] req_wdata_i,
   input  logic [63:0] req_din_i,
   input  logic [63:0] req_dinb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rdata_o,
   output logic [63:0] rsp_err_o,
   output logic [31:0] cwle_o,
   output logic [31:0] cwlo_o,
   output logic [63:0] cblen_o,
   output logic [63:0] cbl_o,
   output logic [63:0] csl_o,
   output logic [63:0] din_o,
   output logic [63:0] dinb_o,
   input  logic [63:0] dout_i
);

   // state      | meaning
   // IDLE       | ready for a request, all macro lines low
   // WL_SETUP   | word line up, columns quiet
   // W_DRIVE    | cbl/csl set for current phase, cblen low
   // W_PULSE    | cblen = mask, cbl/csl held
   // W_HOLD     | cblen low, cbl/csl held
   // R_ARM      | din/dinb driven, csl = mask
   // R_EVAL     | csl low, DOUT captured on the last cycle
   // RELEASE    | every macro line low
   // RESP       | response held until rsp_ready_i
   typedef enum logic [3:0] {
      ST_IDLE, ST_WL_SETUP, ST_W_DRIVE, ST_W_PULSE, ST_W_HOLD,
      ST_R_ARM, ST_R_EVAL, ST_RELEASE, ST_RESP
   } state_e;

   localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                          ? ((SETUP_CYC > EVAL_CYC) ? SETUP_CYC : EVAL_CYC)
                          : ((PULSE_CYC > EVAL_CYC) ? PULSE_CYC : EVAL_CYC);
   localparam int CW = $clog2(MAX_CYC + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          verify_q, verify_d;
   logic          op_we_q, op_we_d;
   logic [5:0]    op_row_q, op_row_d;
   logic [63:0]   op_mask_q, op_mask_d;
   logic [63:0]   op_wdata_q, op_wdata_d;
   logic [63:0]   op_din_q, op_din_d;
   logic [63:0]   op_dinb_q, op_dinb_d;

   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [63:0]   rsp_rdata_q, rsp_rdata_d;
   logic [63:0]   rsp_err_q, rsp_err_d;
   logic [31:0]   cwle_q, cwle_d, cwlo_q, cwlo_d;
   logic [63:0]   cblen_q, cblen_d, cbl_q, cbl_d, csl_q, csl_d;
   logic [63:0]   din_q, din_d, dinb_q, dinb_d;
   logic          wl_on;
   logic          eval_last;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         verify_q   <= 1'b0;
         op_we_q    <= 1'b0;
         op_row_q   <= '0;
         op_mask_q  <= '0;
         op_wdata_q <= '0;
         op_din_q   <= '0;
         op_dinb_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         verify_q   <= verify_d;
         op_we_q    <= op_we_d;
         op_row_q   <= op_row_d;
         op_mask_q  <= op_mask_d;
         op_wdata_q <= op_wdata_d;
         op_din_q   <= op_din_d;
         op_dinb_q  <= op_dinb_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      verify_d   = verify_q;
      op_we_d    = op_we_q;
      op_row_d   = op_row_q;
      op_mask_d  = op_mask_q;
      op_wdata_d = op_wdata_q;
      op_din_d   = op_din_q;
      op_dinb_d  = op_dinb_q;
      case (state_q)
         ST_IDLE: if (req_valid_i) begin
            state_d    = ST_WL_SETUP;
            cnt_d      = CW'(SETUP_CYC - 1);
            phase_d    = 1'b0;
            verify_d   = 1'b0;
            op_we_d    = req_we_i;
            op_row_d   = req_row_i;
            op_mask_d  = req_mask_i;
            op_wdata_d = req_wdata_i;
            op_din_d   = req_din_i;
            op_dinb_d  = req_dinb_i;
         end
         ST_WL_SETUP: begin
            if (cnt_q == '0) state_d = op_we_q ? ST_W_DRIVE : ST_R_ARM;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_W_DRIVE: begin
            state_d = ST_W_PULSE;
            cnt_d   = CW'(PULSE_CYC - 1);
         end
         ST_W_PULSE: begin
            if (cnt_q == '0) state_d = ST_W_HOLD;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_W_HOLD: begin
            if (!phase_q) begin
               state_d = ST_W_DRIVE;
               phase_d = 1'b1;
            end else begin
`ifdef MC_DRV_VERIFY_EN
               // readback reuses the word line already raised for the write
               state_d  = ST_R_ARM;
               verify_d = 1'b1;
`else
               state_d  = ST_RELEASE;
`endif
            end
         end
         ST_R_ARM: begin
            state_d = ST_R_EVAL;
            cnt_d   = CW'(EVAL_CYC - 1);
         end
         ST_R_EVAL: begin
            if (cnt_q == '0) state_d = ST_RELEASE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_RELEASE: state_d = ST_RESP;
         ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight off a flop.
   always_comb begin
      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cwle_d      = '0;
      cwlo_d      = '0;
      cblen_d     = '0;
      cbl_d       = '0;
      csl_d       = '0;
      din_d       = '0;
      dinb_d      = '0;
      wl_on       = state_d inside {ST_WL_SETUP, ST_W_DRIVE, ST_W_PULSE, ST_W_HOLD,
                                    ST_R_ARM, ST_R_EVAL};
      eval_last   = (state_q == ST_R_EVAL) && (cnt_q == '0);
      if (wl_on) begin
         if (op_row_d[0]) cwle_d = 32'h1 << op_row_d[5:1];
         else             cwlo_d = 32'h1 << op_row_d[5:1];
      end
      case (state_d)
         ST_W_DRIVE, ST_W_PULSE, ST_W_HOLD: begin
            cbl_d = ~op_wdata_d & op_mask_d;
            csl_d = phase_d ? (~op_wdata_d & op_mask_d) : (op_wdata_d & op_mask_d);
            if (state_d == ST_W_PULSE) cblen_d = op_mask_d;
         end
         ST_R_ARM, ST_R_EVAL: begin
            din_d  = verify_d ? '1 : op_din_d;
            dinb_d = verify_d ? '0 : op_dinb_d;
            if (state_d == ST_R_ARM) csl_d = op_mask_d;
         end
         default: ;
      endcase
      if (eval_last) begin
`ifdef MC_DRV_VERIFY_EN
         rsp_rdata_d = verify_q ? (~dout_i & op_mask_q) : (dout_i & op_mask_q);
         rsp_err_d   = verify_q ? ((~dout_i ^ op_wdata_q) & op_mask_q) : '0;
`else
         rsp_rdata_d = dout_i & op_mask_q;
         rsp_err_d   = '0;
`endif
      end
      if (state_d == ST_IDLE) begin
         rsp_rdata_d = '0;
         rsp_err_d   = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= '0;
         cwle_q      <= '0;
         cwlo_q      <= '0;
         cblen_q     <= '0;
         cbl_q       <= '0;
         csl_q       <= '0;
         din_q       <= '0;
         dinb_q      <= '0;
      end else begin
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cwle_q      <= cwle_d;
         cwlo_q      <= cwlo_d;
         cblen_q     <= cblen_d;
         cbl_q       <= cbl_d;
         csl_q       <= csl_d;
         din_q       <= din_d;
         dinb_q      <= dinb_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign cwle_o      = cwle_q;
   assign cwlo_o      = cwlo_q;
   assign cblen_o     = cblen_q;
   assign cbl_o       = cbl_q;
   assign csl_o       = csl_q;
   assign din_o       = din_q;
   assign dinb_o      = dinb_q;

endmodule

// File: tb/tb_mc_array_driver.sv
// Directed bench for mc_array_driver with a behavioural crossbar macro model.
// Expectations follow MC_DRV_VERIFY_EN when the bench is built with it defined.
module tb_mc_array_driver;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i;
   logic [5:0]  req_row_i;
   logic [63:0] req_mask_i, req_wdata_i, req_din_i, req_dinb_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [63:0] rsp_rdata_o, rsp_err_o;
   logic [31:0] cwle_o, cwlo_o;
   logic [63:0] cblen_o, cbl_o, csl_o, din_o, dinb_o, dout_i;

   int n_total = 0;
   int n_pass  = 0;

   logic [63:0] mem [64] = '{default: '0};
   logic        act;
   logic [5:0]  act_row;
   logic        stuck7 = 1'b0;

`ifdef MC_DRV_VERIFY_EN
   localparam int W_LAT  = 18;
   localparam int WL_CYC = 17;
`else
   localparam int W_LAT  = 15;
   localparam int WL_CYC = 14;
`endif

   mc_array_driver dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_row_i(req_row_i), .req_mask_i(req_mask_i), .req_wdata_i(req_wdata_i),
      .req_din_i(req_din_i), .req_dinb_i(req_dinb_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .cwle_o(cwle_o), .cwlo_o(cwlo_o), .cblen_o(cblen_o), .cbl_o(cbl_o),
      .csl_o(csl_o), .din_o(din_o), .dinb_o(dinb_o), .dout_i(dout_i)
   );

   initial forever #5 clk_i = ~clk_i;

   // Macro model: cmd 01 sets m0, 10 clears it; read gives din&~m0 | dinb&m0.
   always_comb begin
      act     = 1'b0;
      act_row = '0;
      for (int i = 0; i < 32; i++) begin
         if (cwlo_o[i]) begin act = 1'b1; act_row = 6'(2 * i);     end
         if (cwle_o[i]) begin act = 1'b1; act_row = 6'(2 * i + 1); end
      end
      dout_i = act ? ((din_o & ~mem[act_row]) | (dinb_o & mem[act_row])) : '0;
      if (stuck7) dout_i[7] = 1'b1;
   end

   always @(posedge clk_i) begin
      if (act) begin
         for (int c = 0; c < 64; c++) begin
            if (cblen_o[c] && !cbl_o[c] && csl_o[c]) mem[act_row][c] <= 1'b1;
            else if (cblen_o[c] && cbl_o[c] && !csl_o[c]) mem[act_row][c] <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] macro_or();
      return cbl_o | csl_o | cblen_o | din_o | dinb_o | {cwle_o, cwlo_o};
   endfunction

   task automatic send(input logic we, input logic [5:0] row, input logic [63:0] mask,
                       input logic [63:0] wdata, input logic [63:0] din, input logic [63:0] dinb);
      int w = 0;
      @(negedge clk_i);
      while (!req_ready_o && w < 50) begin @(negedge clk_i); w++; end
      chk("send_ready", {63'b0, req_ready_o}, 64'd1);
      req_we_i = we; req_row_i = row; req_mask_i = mask;
      req_wdata_i = wdata; req_din_i = din; req_dinb_i = dinb;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      req_wdata_i = '1; req_mask_i = '0; req_row_i = 6'd33;
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin lat = k; break; end
      end
   endtask

   task automatic handshake();
      @(negedge clk_i);
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 rsp_ready_i = 1'b0;
   endtask

   initial begin
      int lat, wl_cnt, cblen_cnt, stable, seen;
      logic [63:0] bad;
      rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_row_i = '0;
      req_mask_i = '0; req_wdata_i = '0; req_din_i = '0; req_dinb_i = '0;
      rsp_ready_i = 1'b0;
      #12 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_ready", {63'b0, req_ready_o}, 64'd1);
      chk("rst_valid", {63'b0, rsp_valid_o}, 64'd0);
      chk("rst_rdata", rsp_rdata_o, 64'd0);
      chk("rst_macro", macro_or(), 64'd0);

      // Test 1: write row 0, full mask
      send(1'b1, 6'd0, '1, 64'hA5A5_A5A5_A5A5_A5A5, '0, '0);
      wl_cnt = 0; cblen_cnt = 0; lat = -1;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk_i);
         if (cwlo_o == 32'h1 && cwle_o == 32'h0) wl_cnt++;
         if (cblen_o == '1) cblen_cnt++;
         if (k == 2) begin
            chk("t1_p0_cbl", cbl_o, 64'h5A5A_5A5A_5A5A_5A5A);
            chk("t1_p0_csl", csl_o, 64'hA5A5_A5A5_A5A5_A5A5);
            chk("t1_drive_cblen", cblen_o, 64'd0);
         end
         if (k == 8) begin
            chk("t1_p1_cbl", cbl_o, 64'h5A5A_5A5A_5A5A_5A5A);
            chk("t1_p1_csl", csl_o, 64'h5A5A_5A5A_5A5A_5A5A);
         end
         if (rsp_valid_o) begin lat = k; break; end
      end
      chk("t1_lat", 64'(lat), 64'(W_LAT));
      chk("t1_wl_cycles", 64'(wl_cnt), 64'(WL_CYC));
      chk("t1_cblen_cycles", 64'(cblen_cnt), 64'd8);
      chk("t1_resp_macro", macro_or(), 64'd0);
`ifdef MC_DRV_VERIFY_EN
      chk("t1_rdata", rsp_rdata_o, 64'hA5A5_A5A5_A5A5_A5A5);
`else
      chk("t1_rdata", rsp_rdata_o, 64'd0);
`endif
      chk("t1_err", rsp_err_o, 64'd0);
      handshake();
      @(negedge clk_i);
      chk("t1_idle_ready", {63'b0, req_ready_o}, 64'd1);
      chk("t1_idle_valid", {63'b0, rsp_valid_o}, 64'd0);

      // Test 2: read row 0
      send(1'b0, 6'd0, '1, '0, '1, '0);
      wait_rsp(lat);
      chk("t2_lat", 64'(lat), 64'd6);
      chk("t2_rdata", rsp_rdata_o, 64'h5A5A_5A5A_5A5A_5A5A);
      handshake();

      // Test 3: partial-mask write of row 63, then masked reads
      send(1'b1, 6'd63, 64'h0000_0000_FFFF_0000, '0, '0, '0);
      bad = '0; lat = -1;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk_i);
         bad |= (cbl_o | csl_o | cblen_o) & ~64'h0000_0000_FFFF_0000;
         if (k == 0) begin
            chk("t3_cwle", {32'b0, cwle_o}, 64'h8000_0000);
            chk("t3_cwlo", {32'b0, cwlo_o}, 64'd0);
         end
         if (k == 2) chk("t3_p0_cbl", cbl_o, 64'h0000_0000_FFFF_0000);
         if (k == 3) chk("t3_pulse_cblen", cblen_o, 64'h0000_0000_FFFF_0000);
         if (rsp_valid_o) begin lat = k; break; end
      end
      chk("t3_unmasked_quiet", bad, 64'd0);
      chk("t3_lat", 64'(lat), 64'(W_LAT));
      chk("t3_rdata", rsp_rdata_o, 64'd0);
      handshake();
      send(1'b0, 6'd63, '1, '0, '1, '0);
      wait_rsp(lat);
      chk("t3_rd_full", rsp_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
      handshake();
      send(1'b0, 6'd63, 64'h0000_0000_FFFF_0000, '0, '1, '1);
      wait_rsp(lat);
      chk("t3_rd_masked", rsp_rdata_o, 64'h0000_0000_FFFF_0000);
      handshake();

      // Test 4: response back-pressure with a pending request
      send(1'b0, 6'd0, '1, '0, '1, '0);
      wait_rsp(lat);
      chk("t4_lat", 64'(lat), 64'd6);
      req_we_i = 1'b0; req_row_i = 6'd63; req_mask_i = '1;
      req_din_i = '1; req_dinb_i = '0; req_valid_i = 1'b1;
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (!(rsp_valid_o === 1'b1 && rsp_rdata_o === 64'h5A5A_5A5A_5A5A_5A5A
               && req_ready_o === 1'b0)) stable = 0;
      end
      chk("t4_stable", 64'(stable), 64'd1);
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 rsp_ready_i = 1'b0;
      @(negedge clk_i);
      chk("t4_post_hs_ready", {63'b0, req_ready_o}, 64'd1);
      chk("t4_post_hs_valid", {63'b0, rsp_valid_o}, 64'd0);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      wait_rsp(lat);
      chk("t4_second_lat", 64'(lat), 64'd6);
      chk("t4_second_rdata", rsp_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
      handshake();

      // Test 5: reset during phase-1 pulse
      send(1'b1, 6'd5, '1, 64'h0123_4567_89AB_CDEF, '0, '0);
      for (int k = 0; k <= 10; k++) @(negedge clk_i);
      chk("t5_in_pulse", cblen_o, 64'hFFFF_FFFF_FFFF_FFFF);
      #2 rst_i = 1'b1;
      #1;
      chk("t5_rst_macro", macro_or(), 64'd0);
      chk("t5_rst_ready", {63'b0, req_ready_o}, 64'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk_i);
         if (rsp_valid_o !== 1'b0) seen = 1;
      end
      chk("t5_no_rsp", 64'(seen), 64'd0);
      send(1'b0, 6'd0, '1, '0, '1, '0);
      wait_rsp(lat);
      chk("t5_after_lat", 64'(lat), 64'd6);
      chk("t5_after_rdata", rsp_rdata_o, 64'h5A5A_5A5A_5A5A_5A5A);
      handshake();

      // Test 6: stuck DOUT bit 7 during a write of 0xFF
      stuck7 = 1'b1;
      send(1'b1, 6'd10, '1, 64'hFF, '0, '0);
      wait_rsp(lat);
      chk("t6_lat", 64'(lat), 64'(W_LAT));
`ifdef MC_DRV_VERIFY_EN
      chk("t6_err", rsp_err_o, 64'h80);
      chk("t6_rdata", rsp_rdata_o, 64'h7F);
`else
      chk("t6_err", rsp_err_o, 64'd0);
      chk("t6_rdata", rsp_rdata_o, 64'd0);
`endif
      handshake();
      stuck7 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mc_array_driver.md
Name: mc_array_driver

Overview:
Synchronous controller for the 64x64 memristor crossbar macro (CBL/CBLEN/CSL/DIN/DINb/CWLE/CWLO in, DOUT out). It accepts row-level write and read/compute requests over a valid/ready handshake. It sequences the macro's level-sensitive control lines: word-line setup, two-phase complementary-pair programming, and arm/evaluate read. Read results return over a valid/ready response channel.

Parameters:
SETUP_CYC, 2, cycles the word line is high before any column activity (>=1)
PULSE_CYC, 4, cycles CBLEN is held high per write phase (>=1)
EVAL_CYC, 2, cycles CSL is held low in read evaluate; DOUT sampled on last cycle (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready; high only in IDLE
req_we_i  in  1  1=write, 0=read
req_row_i  in  6  target row
req_mask_i  in  64  column enable
req_wdata_i  in  64  write data
req_din_i  in  64  read operand driven on DIN
req_dinb_i  in  64  read operand driven on DINb
rsp_valid_o  out  1  response valid, held until rsp_ready_i
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  64  read result; 0 for writes
rsp_err_o  out  64  verify mismatch mask (see Optional Feature)
cwle_o  out  32  odd-row word lines
cwlo_o  out  32  even-row word lines
cblen_o, cbl_o, csl_o, din_o, dinb_o  out  64 each  column controls to macro
dout_i  in  64  macro DOUT

Behaviour:
- All outputs are registered. Reset and idle values: every macro output 0, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- Row map: the row is even when r[0]=0, driving cwlo_o[r>>1]. The row is odd when r[0]=1, driving cwle_o[r>>1]. Exactly one word-line bit is high from WL_SETUP through the last op state, inclusive.
- On accept, the request fields are captured in registers. Input changes after accept are ignored.
- States: IDLE -> WL_SETUP(SETUP_CYC) -> write or read branch -> RELEASE(1 cycle, all lines 0) -> RESP -> IDLE when rsp_ready_i is high.
- Write branch: phase 0 sets m0, then phase 1 sets m1. Each phase runs DRIVE(1) -> PULSE(PULSE_CYC) -> HOLD(1).
  - DRIVE: cbl/csl are set on masked columns and cblen_o=0.
  - PULSE: cblen_o=mask, with cbl/csl held.
  - HOLD: cblen_o=0, with cbl/csl held.
  - Phase 0 per masked column: cbl=~wdata, csl=wdata. A 1 gives command 01 (m0=1); a 0 gives 10 (m0=0).
  - Phase 1 per masked column: cbl=~wdata, csl=~wdata. A 1 gives 00 (m1=0); a 0 gives 11 (m1=1).
  - Unmasked columns: cbl=csl=cblen=0 throughout. cbl/csl never change in the same cycle as a cblen edge.
- Read branch:
  - ARM(1): din/dinb are driven from the request, csl_o=mask, cblen_o=0.
  - EVAL(EVAL_CYC): csl_o=0 and din/dinb are held. On the last cycle, rsp_rdata_o <= dout_i & mask; unmasked bits are 0.
  - din/dinb return to 0 in RELEASE.
- Latency from the accepting edge to rsp_valid_o high:
  - write = SETUP_CYC + 2*(PULSE_CYC+2) + 1, which is 15 at defaults;
  - read = SETUP_CYC + 1 + EVAL_CYC + 1, which is 6 at defaults.
- rsp_valid_o and data are stable until the handshake. A new request is not accepted in the same cycle as the response handshake; IDLE is entered on the next cycle.
- A request with mask=0 still runs the full sequence. Word-line timing is identical, and the column lines stay 0.
- Reset asserted mid-operation forces all outputs to idle values immediately, asynchronously. The partially programmed row's contents are undefined, and no response is issued.
- Counters are sized $clog2(max(SETUP_CYC,PULSE_CYC,EVAL_CYC)+1).

Optional Feature:
MC_DRV_VERIFY_EN
- Defined: after write phase 1, the driver runs an internal read in the same word-line window, with no extra WL_SETUP. It uses din=1 and dinb=0, so the macro output is ~m0. Then rsp_err_o = (~dout_i ^ wdata) & mask and rsp_rdata_o = ~dout_i & mask. Write latency increases by 1+EVAL_CYC.
- Undefined: rsp_err_o is tied 0, and the write response carries rdata=0.

Test Plan:
1. Write row 0, mask=all-ones, wdata=0xA5A5_A5A5_A5A5_A5A5 -> cwlo_o[0] high from cycle 1 only. Phase 0 cbl/csl=~wdata/wdata, phase 1 cbl/csl=~wdata/~wdata. cblen high for exactly 4 cycles per phase. rsp_valid at cycle 15.
2. Read row 0 after test 1, din=all-ones, dinb=0, mask=all-ones -> rsp_rdata=0x5A5A_5A5A_5A5A_5A5A at cycle 6 (macro model in loop).
3. Write row 63, mask=0x0000_0000_FFFF_0000, wdata=0 -> only cwle_o[31] rises. Columns outside [31:16] keep cbl/csl/cblen=0. A read with mask=all-ones returns 0 in unmasked bits.
4. Hold rsp_ready_i=0 for 10 cycles with req_valid_i high -> rsp_valid and data stable, req_ready_o=0, and the second request is accepted only after the handshake.
5. Assert rst_i during write PULSE of phase 1 -> all macro outputs 0 in the same cycle, rsp_valid never rises, and the next request proceeds normally.
6. With MC_DRV_VERIFY_EN, force dout_i bit 7 stuck at 1 during verify of a write of 0xFF -> rsp_err_o=0x80 and write latency=18.
